// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX byte interface between NREQ requesters.
// A grant is held for a whole packet (closed by last), with an optional idle gap after it.
module uart_tx_sched #(
    parameter int NREQ = 4,
    parameter int GAPW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_enable_i,
    input  logic [GAPW-1:0]   gap_cycles_i,
    input  logic [NREQ*8-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        tx_d_o,
    output logic              tx_d_valid_o,
    input  logic              tx_d_ready_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     own_q, own_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [GAPW-1:0]   gap_q, gap_d;

    logic              found;
    logic [PW-1:0]     win;
    logic              vld;
    logic              beat;

    // Index arithmetic modulo NREQ, valid for non-power-of-two requester counts.
    function automatic logic [PW-1:0] idx_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        own_d        = own_q;
        ptr_d        = ptr_q;
        gap_d        = gap_q;
        tx_d_o       = '0;
        tx_d_valid_o = 1'b0;
        req_ready_o  = '0;
        found        = 1'b0;
        win          = '0;
        vld          = 1'b0;
        beat         = 1'b0;

        case (state_q)
            IDLE: begin
                // First valid requester at or after ptr wins.
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid_i[idx_add(ptr_q, k)]) begin
                        found = 1'b1;
                        win   = idx_add(ptr_q, k);
                    end
                end
                if (tx_enable_i && found) begin
                    own_d   = win;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    state_d = XFER;
                end
            end
            XFER: begin
                vld                = req_valid_i[own_q] & tx_enable_i;
                beat               = vld & tx_d_ready_i;
                tx_d_o             = req_data_i[int'(own_q)*8 +: 8];
                tx_d_valid_o       = vld;
                req_ready_o[own_q] = tx_d_ready_i & tx_enable_i;
                if (beat && req_last_i[own_q]) begin
                    ptr_d   = idx_add(own_q, 1);
                    grant_d = '0;
                    if (gap_cycles_i != '0) begin
                        gap_d   = gap_cycles_i;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= 1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: inputs change on the falling edge, outputs are
// checked 1ns later, so each check sees the registered state plus current inputs.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_enable;
    logic [7:0]  gap_cycles;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_d;
    logic        tx_d_valid;
    logic        tx_d_ready;
    logic [3:0]  grant;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int beats  = 0;
    int b0;

    uart_tx_sched #(.NREQ(4), .GAPW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_enable_i  (tx_enable),
        .gap_cycles_i (gap_cycles),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .tx_d_o       (tx_d),
        .tx_d_valid_o (tx_d_valid),
        .tx_d_ready_i (tx_d_ready),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && tx_d_valid && tx_d_ready) beats <= beats + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic setreq(input int i, input logic [7:0] d, input logic v, input logic l);
        req_data[i*8 +: 8] = d;
        req_valid[i]       = v;
        req_last[i]        = l;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        req_last  = '0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        tx_enable  = 1'b1;
        gap_cycles = 8'd0;
        req_data   = '0;
        req_valid  = '0;
        req_last   = '0;
        tx_d_ready = 1'b1;
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_txv", tx_d_valid, 1'b0);
        check("rst_txd", tx_d, 8'h00);
        check("rst_ready", req_ready, 4'b0000);
        check("rst_ptr", dut.ptr_q, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, 3-byte packet.
        b0 = beats;
        cyc(); setreq(2, 8'h41, 1, 0); #1;
        check("s_idle_grant", grant, 4'b0000);
        check("s_idle_txv", tx_d_valid, 1'b0);
        cyc(); #1;
        check("s_grant", grant, 4'b0100);
        check("s_b0_txd", tx_d, 8'h41);
        check("s_b0_txv", tx_d_valid, 1'b1);
        check("s_b0_ready", req_ready, 4'b0100);
        cyc(); setreq(2, 8'h42, 1, 0); #1;
        check("s_b1_txd", tx_d, 8'h42);
        cyc(); setreq(2, 8'h43, 1, 1); #1;
        check("s_b2_txd", tx_d, 8'h43);
        check("s_b2_txv", tx_d_valid, 1'b1);
        cyc(); setreq(2, 8'h00, 0, 0); #1;
        check("s_end_grant", grant, 4'b0000);
        check("s_end_busy", busy, 1'b0);
        check("s_ptr", dut.ptr_q, 2'd3);
        check("s_beats", beats - b0, 3);

        // Round robin with all four requesters holding 1-byte packets.
        do_reset();
        for (int i = 0; i < 4; i++) setreq(i, 8'h10 + 8'(i), 1, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_gap_grant", grant, 4'b0000);
            cyc(); #1;
            check("rr_grant", grant, 4'b0001 << (i % 4));
            check("rr_txd", tx_d, 8'h10 + (i % 4));
            cyc();
        end
        req_valid = '0;

        // Packet locking: req 1 must wait for req 0's last beat.
        do_reset();
        cyc(); setreq(0, 8'hA0, 1, 0); #1;
        cyc(); #1;
        check("lk_grant0", grant, 4'b0001);
        check("lk_txd0", tx_d, 8'hA0);
        cyc(); setreq(0, 8'hA1, 1, 0); setreq(1, 8'hB0, 1, 1); #1;
        check("lk_hold1", grant, 4'b0001);
        check("lk_txd1", tx_d, 8'hA1);
        check("lk_ready1", req_ready, 4'b0001);
        cyc(); setreq(0, 8'hA2, 1, 0); #1;
        check("lk_txd2", tx_d, 8'hA2);
        cyc(); setreq(0, 8'hA3, 1, 1); #1;
        check("lk_txd3", tx_d, 8'hA3);
        check("lk_hold3", grant, 4'b0001);
        cyc(); setreq(0, 8'h00, 0, 0); #1;
        check("lk_idle", grant, 4'b0000);
        cyc(); #1;
        check("lk_grant1", grant, 4'b0010);
        check("lk_txdB", tx_d, 8'hB0);
        cyc(); setreq(1, 8'h00, 0, 0); #1;
        check("lk_end", busy, 1'b0);

        // Backpressure and enable drop on req 3.
        do_reset();
        b0 = beats;
        cyc(); setreq(3, 8'hC0, 1, 0); tx_d_ready = 1'b1; #1;
        cyc(); #1;
        check("bp_grant", grant, 4'b1000);
        check("bp_txd0", tx_d, 8'hC0);
        cyc(); setreq(3, 8'hC1, 1, 0); tx_d_ready = 1'b0; #1;
        check("bp_txv_r0", tx_d_valid, 1'b1);
        check("bp_ready_r0", req_ready, 4'b0000);
        cyc(); #1;
        check("bp_txd_hold", tx_d, 8'hC1);
        cyc(); tx_d_ready = 1'b1; #1;
        check("bp_ready_r1", req_ready, 4'b1000);
        cyc(); setreq(3, 8'hC2, 1, 0); tx_enable = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_dis_txv", tx_d_valid, 1'b0);
            check("bp_dis_ready", req_ready, 4'b0000);
            check("bp_dis_grant", grant, 4'b1000);
            cyc(); #1;
        end
        tx_enable = 1'b1; #1;
        check("bp_txd2", tx_d, 8'hC2);
        check("bp_txv2", tx_d_valid, 1'b1);
        cyc(); setreq(3, 8'hC3, 1, 1); #1;
        check("bp_txd3", tx_d, 8'hC3);
        cyc(); setreq(3, 8'h00, 0, 0); #1;
        check("bp_end_grant", grant, 4'b0000);
        check("bp_beats", beats - b0, 4);

        // Inter-packet gap of 5 cycles; a change mid-gap is ignored.
        do_reset();
        gap_cycles = 8'd5;
        cyc(); setreq(0, 8'hD0, 1, 1); setreq(1, 8'hD1, 1, 1); #1;
        cyc(); #1;
        check("gp_grant0", grant, 4'b0001);
        check("gp_txd0", tx_d, 8'hD0);
        cyc(); setreq(0, 8'h00, 0, 0); gap_cycles = 8'd2; #1;
        for (int i = 0; i < 5; i++) begin
            check("gp_busy", busy, 1'b1);
            check("gp_grant", grant, 4'b0000);
            check("gp_txv", tx_d_valid, 1'b0);
            cyc(); gap_cycles = 8'd0; #1;
        end
        check("gp_idle_busy", busy, 1'b0);
        cyc(); #1;
        check("gp_grant1", grant, 4'b0010);
        check("gp_txd1", tx_d, 8'hD1);
        cyc(); setreq(1, 8'h00, 0, 0); #1;
        check("gp_end", busy, 1'b0);

        // Asynchronous reset in the middle of a 4-byte packet.
        do_reset();
        cyc(); setreq(0, 8'hE0, 1, 0); #1;
        cyc(); #1;
        check("rm_grant", grant, 4'b0001);
        cyc(); setreq(0, 8'hE1, 1, 0); setreq(1, 8'hF0, 1, 1); #1;
        rst_n = 1'b0; #1;
        check("rm_grant0", grant, 4'b0000);
        check("rm_txv0", tx_d_valid, 1'b0);
        check("rm_txd0", tx_d, 8'h00);
        check("rm_ready0", req_ready, 4'b0000);
        check("rm_busy0", busy, 1'b0);
        cyc(); rst_n = 1'b1; setreq(0, 8'hE0, 1, 0); #1;
        check("rm_idle", grant, 4'b0000);
        cyc(); #1;
        check("rm_regrant", grant, 4'b0001);
        check("rm_txd", tx_d, 8'hE0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
